// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//
// Issue/capture stage that sits in front of the 32-bit gate-level ALU.
// An operation is accepted over a valid/ready handshake. Its operands and
// command are then driven to the ALU from registers and held steady for
// SETTLE_CYCLES clocks, which covers the ALU's ripple/gate delay. After that
// window the ALU result and flags are registered and offered downstream over
// a second valid/ready handshake.
//
// Parameters:
//   SETTLE_CYCLES  clocks from accept to capture (>= 1); SETTLE_CYCLES*Tclk
//                  must exceed the ALU worst-case delay
//   CNT_W          settle counter width, must hold SETTLE_CYCLES-1
//
// Ports:
//   clk, reset                 single clock; synchronous active-high reset
//   in_valid / in_ready        request handshake
//   in_operandA/B, in_command  request payload
//   alu_operandA/B, alu_command  registered drive into the ALU
//   alu_result, alu_carryout,
//   alu_zero, alu_overflow     raw ALU outputs
//   out_valid / out_ready      result handshake
//   out_result, out_carryout,
//   out_zero, out_overflow,
//   out_command                captured result, masked flags, producing command

module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_operandA,
    input  logic [31:0] in_operandB,
    input  logic [2:0]  in_command,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [2:0]  alu_command,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_carryout,
    output logic        out_zero,
    output logic        out_overflow,
    output logic [2:0]  out_command
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             accept;
    logic             arith_cmd;

    // A new request can be taken when idle, or in DONE when the consumer pops
    // the current result on the same edge (back-to-back issue).
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Carry and overflow only mean something for ADD/SUB; for the logic ops
    // the ALU may leave them undefined, so the select below forces them to 0
    // rather than letting an unknown value through.
    assign arith_cmd = (alu_command == 3'b000) || (alu_command == 3'b001);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            alu_operandA <= '0;
            alu_operandB <= '0;
            alu_command  <= 3'b000;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_command  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_operandA <= in_operandA;
                        alu_operandB <= in_operandB;
                        alu_command  <= in_command;
                        counter      <= CNT_W'(SETTLE_CYCLES - 1);
                        state        <= SETTLE;
                    end
                end

                SETTLE: begin
                    // counter==0 marks the SETTLE_CYCLES-th edge after accept
                    if (counter != '0) begin
                        counter <= counter - CNT_W'(1);
                    end else begin
                        out_result   <= alu_result;
                        out_zero     <= alu_zero;
                        out_carryout <= arith_cmd ? alu_carryout : 1'b0;
                        out_overflow <= arith_cmd ? alu_overflow : 1'b0;
                        out_command  <= alu_command;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            alu_operandA <= in_operandA;
                            alu_operandB <= in_operandB;
                            alu_command  <= in_command;
                            counter      <= CNT_W'(SETTLE_CYCLES - 1);
                            state        <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int SETTLE_CYCLES = 4;
    localparam int CNT_W         = 3;
    localparam int ALU_DELAY     = 3400;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic        zero;
        logic        ovf;
    } alu_out_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_operandA;
    logic [31:0] in_operandB;
    logic [2:0]  in_command;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [2:0]  alu_command;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carryout;
    logic        out_zero;
    logic        out_overflow;
    logic [2:0]  out_command;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_issue_ctrl #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_operandA (in_operandA),
        .in_operandB (in_operandB),
        .in_command  (in_command),
        .alu_operandA(alu_operandA),
        .alu_operandB(alu_operandB),
        .alu_command (alu_command),
        .alu_result  (alu_result),
        .alu_carryout(alu_carryout),
        .alu_zero    (alu_zero),
        .alu_overflow(alu_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_carryout(out_carryout),
        .out_zero    (out_zero),
        .out_overflow(out_overflow),
        .out_command (out_command)
    );

    // 1000-unit clock period, rising edges at 500, 1500, ...
    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    // Reference ALU behaviour. Carry and overflow of the logic ops are driven
    // to 1 as a stand-in for "undefined", so that any leak through the mask
    // shows up as a wrong flag.
    function automatic alu_out_t aluFunc(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        alu_out_t    o;
        logic [32:0] sum;
        o.result = '0;
        o.carry  = 1'b1;
        o.ovf    = 1'b1;
        sum      = '0;
        case (cmd)
            CMD_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                o.result = sum[31:0];
                o.carry  = sum[32];
                o.ovf    = (a[31] == b[31]) && (o.result[31] != a[31]);
            end
            CMD_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o.result = sum[31:0];
                o.carry  = sum[32];
                o.ovf    = (a[31] != b[31]) && (o.result[31] != a[31]);
            end
            CMD_XOR:  o.result = a ^ b;
            CMD_SLT:  o.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            CMD_AND:  o.result = a & b;
            CMD_NAND: o.result = ~(a & b);
            CMD_NOR:  o.result = ~(a | b);
            default:  o.result = a | b;
        endcase
        o.zero = (o.result == 32'd0);
        return o;
    endfunction

    // What the block must present for a request: ALU outputs with carry and
    // overflow forced to 0 for anything other than ADD/SUB.
    function automatic alu_out_t expectFunc(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        alu_out_t o;
        o = aluFunc(cmd, a, b);
        if (cmd != CMD_ADD && cmd != CMD_SUB) begin
            o.carry = 1'b0;
            o.ovf   = 1'b0;
        end
        return o;
    endfunction

    // ALU stub: remember when its inputs last moved.
    time last_change = 0;
    always @(alu_operandA or alu_operandB or alu_command) last_change = $time;

    // ALU stub: outputs are the inverse of the right answer until ALU_DELAY
    // has passed since the inputs moved, so an early capture is visible. The
    // poll is offset by 50 so it never shares a timestep with a clock edge.
    alu_out_t stub_val;
    initial begin
        #50;
        forever begin
            stub_val = aluFunc(alu_command, alu_operandA, alu_operandB);
            if (($time - last_change) < ALU_DELAY) stub_val = ~stub_val;
            alu_result   = stub_val.result;
            alu_carryout = stub_val.carry;
            alu_zero     = stub_val.zero;
            alu_overflow = stub_val.ovf;
            #100;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model, timestamp based: it tracks whether an operation is
    // in flight and the edge index at which its result becomes visible.
    int       cyc        = 0;
    bit       armed      = 0;
    bit       m_busy     = 0;
    int       m_ready_at = 0;
    logic [31:0] m_alu_a = '0;
    logic [31:0] m_alu_b = '0;
    logic [2:0]  m_alu_cmd = '0;
    alu_out_t m_exp      = '0;

    // Advance the model on every rising edge using the inputs the bench drove
    // during the previous cycle.
    always @(posedge clk) begin
        bit vis;
        bit rdy;
        vis = m_busy && (cyc >= m_ready_at);
        rdy = !m_busy || (vis && out_ready);
        cyc = cyc + 1;
        if (reset) begin
            armed     = 1;
            m_busy    = 0;
            m_alu_a   = '0;
            m_alu_b   = '0;
            m_alu_cmd = '0;
            m_exp     = '0;
        end else if (in_valid && rdy) begin
            m_busy     = 1;
            m_ready_at = cyc + SETTLE_CYCLES;
            m_alu_a    = in_operandA;
            m_alu_b    = in_operandB;
            m_alu_cmd  = in_command;
            m_exp      = expectFunc(in_command, in_operandA, in_operandB);
        end else if (vis && out_ready) begin
            m_busy = 0;
        end
    end

    // Compare DUT against the model on every falling edge once a reset has
    // put both into a known state.
    always @(negedge clk) begin
        bit vis;
        if (armed) begin
            vis = m_busy && (cyc >= m_ready_at);
            checkBit("cmp_out_valid", out_valid, vis);
            checkBit("cmp_in_ready", in_ready, !m_busy || (vis && out_ready));
            checkOutput("cmp_alu_operandA", alu_operandA, m_alu_a);
            checkOutput("cmp_alu_operandB", alu_operandB, m_alu_b);
            checkOutput("cmp_alu_command", {29'd0, alu_command}, {29'd0, m_alu_cmd});
            if (vis) begin
                checkOutput("cmp_out_result", out_result, m_exp.result);
                checkBit("cmp_out_carryout", out_carryout, m_exp.carry);
                checkBit("cmp_out_zero", out_zero, m_exp.zero);
                checkBit("cmp_out_overflow", out_overflow, m_exp.ovf);
                checkOutput("cmp_out_command", {29'd0, out_command}, {29'd0, m_alu_cmd});
            end
        end
    end

    // Move to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        in_valid    = valid;
        in_command  = cmd;
        in_operandA = a;
        in_operandB = b;
    endtask

    // Issue one operation from IDLE, scramble the inputs after accept, and
    // pin the capture timing and the captured values with literals.
    task automatic runOp(input string name, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_result, input logic exp_carry, input logic exp_zero,
                         input logic exp_ovf);
        cycle();
        applyStimulus(1'b1, cmd, a, b);
        cycle();
        applyStimulus(1'b0, ~cmd, ~a, ~b);
        repeat (SETTLE_CYCLES - 1) cycle();
        @(negedge clk);
        checkBit({name, "_not_early"}, out_valid, 1'b0);
        cycle();
        @(negedge clk);
        checkBit({name, "_valid"}, out_valid, 1'b1);
        checkOutput({name, "_result"}, out_result, exp_result);
        checkBit({name, "_carry"}, out_carryout, exp_carry);
        checkBit({name, "_zero"}, out_zero, exp_zero);
        checkBit({name, "_ovf"}, out_overflow, exp_ovf);
        checkOutput({name, "_cmd"}, {29'd0, out_command}, {29'd0, cmd});
        checkOutput({name, "_alu_hold"}, alu_operandA, a);
    endtask

    task automatic popResult();
        cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    // Streaming ops for the always-ready consumer section.
    logic [2:0]  s_cmd [6] = '{CMD_SUB, CMD_SLT, CMD_NAND, CMD_NOR, CMD_OR, CMD_ADD};
    logic [31:0] s_a   [6] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF, 32'hFFFFFFFF};
    logic [31:0] s_b   [6] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFF0000, 32'hFFFFFFFF};

    // Main directed sequence.
    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) cycle();
        reset = 1'b0;

        @(negedge clk);
        checkBit("reset_out_valid", out_valid, 1'b0);
        checkBit("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_alu_command", {29'd0, alu_command}, 32'd0);
        checkOutput("reset_alu_operandA", alu_operandA, 32'd0);
        checkOutput("reset_out_result", out_result, 32'd0);
        checkBit("reset_out_flags", out_carryout | out_zero | out_overflow, 1'b0);

        runOp("add_wrap", CMD_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        popResult();
        runOp("add_ovf", CMD_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
        popResult();
        runOp("and_mask", CMD_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        popResult();
        runOp("sub_ovf", CMD_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
        popResult();

        // Consumer stalls in DONE, then pops while a new request is waiting.
        runOp("xor_stall", CMD_XOR, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk);
            checkBit("stall_out_valid", out_valid, 1'b1);
            checkBit("stall_in_ready", in_ready, 1'b0);
            checkOutput("stall_out_result", out_result, 32'hEDCB5678);
            checkOutput("stall_alu_operandA", alu_operandA, 32'h12345678);
        end
        cycle();
        out_ready = 1'b1;
        applyStimulus(1'b1, CMD_ADD, 32'd3, 32'd4);
        @(negedge clk);
        checkBit("popacc_in_ready", in_ready, 1'b1);
        cycle();
        out_ready = 1'b0;
        applyStimulus(1'b0, CMD_OR, 32'hAAAAAAAA, 32'h55555555);
        @(negedge clk);
        checkBit("popacc_out_valid_low", out_valid, 1'b0);
        checkBit("popacc_in_ready_low", in_ready, 1'b0);
        checkOutput("popacc_alu_operandA", alu_operandA, 32'd3);
        repeat (SETTLE_CYCLES - 1) cycle();
        @(negedge clk);
        checkBit("popacc_not_early", out_valid, 1'b0);
        cycle();
        @(negedge clk);
        checkBit("popacc_valid", out_valid, 1'b1);
        checkOutput("popacc_result", out_result, 32'd7);
        popResult();

        // Reset lands two edges after accept: the operation is dropped.
        cycle();
        applyStimulus(1'b1, CMD_ADD, 32'd1, 32'd2);
        cycle();
        applyStimulus(1'b0, CMD_ADD, 32'd0, 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkBit("abort_out_valid", out_valid, 1'b0);
            checkBit("abort_in_ready", in_ready, 1'b1);
            checkOutput("abort_alu_operandA", alu_operandA, 32'd0);
            cycle();
        end

        // Always-ready consumer with back-to-back requests; the model checks.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int n;
            applyStimulus(1'b1, s_cmd[i], s_a[i], s_b[i]);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkBit("stream_accept_bound", (n < 20) ? 1'b1 : 1'b0, 1'b1);
            cycle();
        end
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (3 * SETTLE_CYCLES) cycle();
        out_ready = 1'b0;
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
